// File: rtl/reg_file_mp.sv
// Multi-port integer register file with qualified write-to-read bypass,
// optional hardwired-zero x0, selectable read latency and a pending-producer scoreboard.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int READ_LAT = 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NRD-1:0]      rd_en_in,
    input  logic [NRD*AW-1:0]   rd_addr_in,
    output logic [NRD*XLEN-1:0] rs_data_out,
    input  logic [NWR-1:0]      wr_en_in,
    input  logic [NWR*AW-1:0]   wr_addr_in,
    input  logic [NWR*XLEN-1:0] wr_data_in,
    input  logic                sb_set_en_in,
    input  logic [AW-1:0]       sb_set_addr,
    input  logic                sb_flush_in,
    output logic [NRD-1:0]      busy_out,
    output logic [NREGS-1:0]    pending_out
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] pending_r;
    logic [AW-1:0]    rd_addr_s [NRD];
    logic [AW-1:0]    wr_addr_s [NWR];
    logic [XLEN-1:0]  wr_data_s [NWR];
    logic [NWR-1:0]   wr_eff_s;
    logic [NREGS-1:0] wr_hit_s;
    logic [NREGS-1:0] set_vec_s;
    logic [XLEN-1:0]  byp_s [NRD];
    logic [NRD-1:0]   rd_wr_hit_s;

    // Unpack the flat address/data buses into per-port views.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_addr_s[r] = rd_addr_in[r*AW +: AW];
        end
        for (int w = 0; w < NWR; w++) begin
            wr_addr_s[w] = wr_addr_in[w*AW +: AW];
            wr_data_s[w] = wr_data_in[w*XLEN +: XLEN];
        end
    end

    // Qualify writes (x0 writes dropped when hardwired) and build the per-register write-hit mask.
    always_comb begin
        wr_eff_s = '0;
        wr_hit_s = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_in[w] && !(ZERO_EN && (wr_addr_s[w] == {AW{1'b0}}))) begin
                wr_eff_s[w]              = 1'b1;
                wr_hit_s[wr_addr_s[w]]   = 1'b1;
            end else begin
                wr_eff_s[w]              = 1'b0;
            end
        end
    end

    // One-hot scoreboard set request; x0 is never marked pending when hardwired.
    always_comb begin
        set_vec_s = '0;
        if (sb_set_en_in && !(ZERO_EN && (sb_set_addr == {AW{1'b0}}))) begin
            set_vec_s[sb_set_addr] = 1'b1;
        end else begin
            set_vec_s = '0;
        end
    end

    // Bypass value and busy per read port; ascending scan lets the highest write port win.
    always_comb begin
        rd_wr_hit_s = '0;
        busy_out    = '0;
        for (int r = 0; r < NRD; r++) begin
            byp_s[r] = regs_r[rd_addr_s[r]];
            for (int w = 0; w < NWR; w++) begin
                if (wr_eff_s[w] && (wr_addr_s[w] == rd_addr_s[r])) begin
                    byp_s[r]       = wr_data_s[w];
                    rd_wr_hit_s[r] = 1'b1;
                end else begin
                    byp_s[r]       = byp_s[r];
                end
            end
            if (ZERO_EN && (rd_addr_s[r] == {AW{1'b0}})) begin
                byp_s[r] = {XLEN{1'b0}};
            end else begin
                byp_s[r] = byp_s[r];
            end
            busy_out[r] = pending_r[rd_addr_s[r]] & ~rd_wr_hit_s[r];
        end
    end

    // Register array commit; later ports overwrite earlier ones on an address collision.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_eff_s[w]) begin
                    regs_r[wr_addr_s[w]] <= wr_data_s[w];
                end
            end
        end
    end

    // Scoreboard: flush beats set, set beats a same-cycle writeback clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pending_r <= {NREGS{1'b0}};
        end else if (sb_flush_in) begin
            pending_r <= {NREGS{1'b0}};
        end else begin
            pending_r <= (pending_r & ~wr_hit_s) | set_vec_s;
        end
    end

    assign pending_out = pending_r;

    if (READ_LAT == 1) begin : g_rd_reg
        logic [NRD*XLEN-1:0] rs_data_r;

        // Registered read; a deasserted enable stalls the port by holding its data.
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                rs_data_r <= {(NRD*XLEN){1'b0}};
            end else begin
                for (int r = 0; r < NRD; r++) begin
                    if (rd_en_in[r]) begin
                        rs_data_r[r*XLEN +: XLEN] <= byp_s[r];
                    end
                end
            end
        end

        assign rs_data_out = rs_data_r;
    end else begin : g_rd_comb
        // Combinational read straight from the bypass network.
        always_comb begin
            rs_data_out = {(NRD*XLEN){1'b0}};
            for (int r = 0; r < NRD; r++) begin
                rs_data_out[r*XLEN +: XLEN] = byp_s[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (NRD=2, NWR=2, ZERO_REG=1, READ_LAT=1): directed table,
// mid-write reset sequence and randomized traffic against an array-based reference model.
module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic [NRD-1:0]      rd_en_in;
    logic [NRD*AW-1:0]   rd_addr_in;
    logic [NRD*XLEN-1:0] rs_data_out;
    logic [NWR-1:0]      wr_en_in;
    logic [NWR*AW-1:0]   wr_addr_in;
    logic [NWR*XLEN-1:0] wr_data_in;
    logic                sb_set_en_in;
    logic [AW-1:0]       sb_set_addr;
    logic                sb_flush_in;
    logic [NRD-1:0]      busy_out;
    logic [NREGS-1:0]    pending_out;

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR),
        .ZERO_REG(1), .READ_LAT(1)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in), .rs_data_out(rs_data_out),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .sb_set_en_in(sb_set_en_in), .sb_set_addr(sb_set_addr), .sb_flush_in(sb_flush_in),
        .busy_out(busy_out), .pending_out(pending_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0]  rd_en;
        logic [4:0]  ra0, ra1;
        logic [1:0]  wr_en;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        set_en;
        logic [4:0]  sa;
        logic        flush;
        logic [31:0] e0, e1;
        logic [1:0]  eb;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_regs [NREGS];
    logic [31:0] m_pend;
    logic [31:0] m_rs [NRD];

    function automatic vec_t mk(logic [1:0] rd_en, logic [4:0] ra0, logic [4:0] ra1,
                                logic [1:0] wr_en, logic [4:0] wa0, logic [31:0] wd0,
                                logic [4:0] wa1, logic [31:0] wd1, logic set_en,
                                logic [4:0] sa, logic flush, logic [31:0] e0,
                                logic [31:0] e1, logic [1:0] eb);
        vec_t v;
        v.rd_en = rd_en; v.ra0 = ra0; v.ra1 = ra1; v.wr_en = wr_en;
        v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.set_en = set_en; v.sa = sa; v.flush = flush;
        v.e0 = e0; v.e1 = e1; v.eb = eb;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] wa_of(int w);
        return wr_addr_in[w*AW +: AW];
    endfunction

    function automatic logic [31:0] wd_of(int w);
        return wr_data_in[w*XLEN +: XLEN];
    endfunction

    // Value a read of register a sees this cycle: zero for x0, else newest winning write, else stored.
    function automatic logic [31:0] m_read(logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        for (int w = NWR - 1; w >= 0; w--) begin
            if (wr_en_in[w] && wa_of(w) == a) return wd_of(w);
        end
        return m_regs[a];
    endfunction

    function automatic bit m_written(logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_in[w] && wa_of(w) == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_busy();
        logic [1:0] b;
        for (int r = 0; r < NRD; r++) begin
            logic [4:0] a;
            a = rd_addr_in[r*AW +: AW];
            b[r] = (a != 5'd0) && m_pend[a] && !m_written(a);
        end
        return b;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 32'd0;
        m_pend = 32'd0;
        for (int r = 0; r < NRD; r++) m_rs[r] = 32'd0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic m_commit();
        for (int r = 0; r < NRD; r++) begin
            if (rd_en_in[r]) m_rs[r] = m_read(rd_addr_in[r*AW +: AW]);
        end
        if (sb_flush_in) begin
            m_pend = 32'd0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en_in[w] && wa_of(w) != 5'd0) m_pend[wa_of(w)] = 1'b0;
            end
            if (sb_set_en_in && sb_set_addr != 5'd0) m_pend[sb_set_addr] = 1'b1;
        end
        for (int w = 0; w < NWR; w++) begin
            if (wr_en_in[w] && wa_of(w) != 5'd0) m_regs[wa_of(w)] = wd_of(w);
        end
    endtask

    task automatic drive(vec_t v);
        rd_en_in     = v.rd_en;
        rd_addr_in   = {v.ra1, v.ra0};
        wr_en_in     = v.wr_en;
        wr_addr_in   = {v.wa1, v.wa0};
        wr_data_in   = {v.wd1, v.wd0};
        sb_set_en_in = v.set_en;
        sb_set_addr  = v.sa;
        sb_flush_in  = v.flush;
    endtask

    // One cycle: drive at posedge+1, check combinational outputs, clock, then check registered outputs.
    task automatic cycle(vec_t v, bit use_tab, string tag);
        logic [1:0] eb;
        drive(v);
        #2;
        eb = use_tab ? v.eb : m_busy();
        check({tag, " busy"}, 64'(busy_out), 64'(eb));
        check({tag, " pending"}, 64'(pending_out), 64'(m_pend));
        @(posedge clk_in);
        #1;
        m_commit();
        check({tag, " rs0"}, 64'(rs_data_out[31:0]),  64'(use_tab ? v.e0 : m_rs[0]));
        check({tag, " rs1"}, 64'(rs_data_out[63:32]), 64'(use_tab ? v.e1 : m_rs[1]));
    endtask

    vec_t tab [18];
    vec_t idle;

    initial begin
        idle = mk(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 2'b00);
        tab[0]  = mk(2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 2'b00);
        tab[1]  = mk(2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 2'b00);
        tab[2]  = mk(2'b11, 5'd5, 5'd7, 2'b01, 5'd7, 32'h12345678, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'h12345678, 2'b00);
        tab[3]  = mk(2'b11, 5'd7, 5'd7, 2'b00, 5'd7, 32'hAAAAAAAA, 5'd7, 32'hBBBBBBBB, 1'b0, 5'd0, 1'b0, 32'h12345678, 32'h12345678, 2'b00);
        tab[4]  = mk(2'b11, 5'd0, 5'd0, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 32'd0, 32'd0, 2'b00);
        tab[5]  = mk(2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 32'd0, 32'd0, 2'b00);
        tab[6]  = mk(2'b11, 5'd3, 5'd3, 2'b11, 5'd3, 32'h1, 5'd3, 32'h2, 1'b0, 5'd0, 1'b0, 32'h2, 32'h2, 2'b00);
        tab[7]  = mk(2'b01, 5'd3, 5'd3, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'h2, 32'h2, 2'b00);
        tab[8]  = mk(2'b00, 5'd9, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'h2, 32'h2, 2'b00);
        tab[9]  = mk(2'b00, 5'd9, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'h2, 32'h2, 2'b01);
        tab[10] = mk(2'b01, 5'd9, 5'd0, 2'b01, 5'd9, 32'h55, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'h55, 32'h2, 2'b00);
        tab[11] = mk(2'b00, 5'd9, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'h55, 32'h2, 2'b00);
        tab[12] = mk(2'b00, 5'd9, 5'd0, 2'b10, 5'd0, 32'd0, 5'd9, 32'h66, 1'b1, 5'd9, 1'b0, 32'h55, 32'h2, 2'b00);
        tab[13] = mk(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'h66, 32'h2, 2'b01);
        tab[14] = mk(2'b00, 5'd4, 5'd6, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 32'h66, 32'h2, 2'b00);
        tab[15] = mk(2'b00, 5'd4, 5'd6, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 32'h66, 32'h2, 2'b01);
        tab[16] = mk(2'b00, 5'd4, 5'd6, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h66, 32'h2, 2'b11);
        tab[17] = mk(2'b00, 5'd4, 5'd6, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'h66, 32'h2, 2'b00);

        // Reset state
        rst_in = 1'b0;
        drive(idle);
        m_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check("reset rs", 64'(rs_data_out), 64'd0);
        check("reset busy", 64'(busy_out), 64'd0);
        check("reset pending", 64'(pending_out), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Directed table
        for (int i = 0; i < 18; i++) begin
            cycle(tab[i], 1'b1, $sformatf("tab%0d", i));
        end
        check("flush pending", 64'(pending_out), 64'd0);

        // Reset asserted in the middle of a write cycle
        cycle(mk(2'b11, 5'd12, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 32'd0, 32'd0, 2'b00),
              1'b0, "pre_rst");
        drive(mk(2'b11, 5'd12, 5'd5, 2'b01, 5'd12, 32'hCAFEF00D, 5'd0, 32'd0, 1'b1, 5'd13, 1'b0, 32'd0, 32'd0, 2'b00));
        #2;
        rst_in = 1'b0;
        #1;
        check("midrst rs", 64'(rs_data_out), 64'd0);
        check("midrst pending", 64'(pending_out), 64'd0);
        check("midrst busy", 64'(busy_out), 64'd0);
        @(posedge clk_in);
        #1;
        check("midrst hold rs", 64'(rs_data_out), 64'd0);
        @(negedge clk_in);
        drive(idle);
        rst_in = 1'b1;
        m_reset();
        @(posedge clk_in);
        #1;
        cycle(mk(2'b11, 5'd12, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 2'b00),
              1'b1, "post_rst");

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = idle;
            v.rd_en  = 2'($urandom_range(0, 3));
            v.ra0    = 5'($urandom_range(0, 7));
            v.ra1    = 5'($urandom_range(0, 7));
            v.wr_en  = 2'($urandom_range(0, 3));
            v.wa0    = 5'($urandom_range(0, 7));
            v.wa1    = 5'($urandom_range(0, 7));
            v.wd0    = $urandom;
            v.wd1    = $urandom;
            v.set_en = ($urandom_range(0, 2) == 0);
            v.sa     = 5'($urandom_range(0, 7));
            v.flush  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) v.ra0 = 5'($urandom_range(0, 31));
            cycle(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
